// File: rtl/muxn_arb.sv
// muxn_arb: N-channel arbitrated mux, registered output, valid/ready on all ports.
// Optional burst lock enabled by defining MUXN_ARB_LOCK_EN.
module muxn_arb #(
    parameter int WIDTH = 32,
    parameter int N = 4,
    parameter int MODE = 1,
    localparam int SELW = $clog2(N)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [N-1:0]       req_valid,
    input  logic [N*WIDTH-1:0] req_data,
`ifdef MUXN_ARB_LOCK_EN
    input  logic [N-1:0]       req_lock,
`endif
    output logic [N-1:0]       req_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_sel,
    input  logic               out_ready
);

    // {found, index} of the lowest set bit of v
    function automatic logic [SELW:0] pick_low(input logic [N-1:0] v);
        logic [SELW:0] r;
        r = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) r = {1'b1, SELW'(i)};
        end
        return r;
    endfunction

    logic [SELW-1:0]  ptr;
    logic [N-1:0]     elig;
    logic [N-1:0]     rot;
    logic [SELW:0]    base;
    logic [SELW:0]    pick;
    logic [SELW:0]    rr_sum;
    logic [SELW-1:0]  win;
    logic             any;
    logic             slot_free;
    logic             xfer;
    logic [WIDTH-1:0] chan [N];

    assign slot_free = ~out_valid | out_ready;
    assign xfer      = any & slot_free;

    // Split the flat payload bus into per-channel words
    always_comb begin
        for (int i = 0; i < N; i++) begin
            chan[i] = req_data[i*WIDTH +: WIDTH];
        end
    end

`ifdef MUXN_ARB_LOCK_EN
    logic            lock_on;
    logic [SELW-1:0] lock_id;

    // While locked only the owning channel may compete
    always_comb begin
        elig = req_valid;
        if (lock_on) elig = req_valid & (N'(1) << lock_id);
    end

    // Lock follows the lock bit of every accepted beat
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_on <= 1'b0;
            lock_id <= '0;
        end else if (xfer) begin
            lock_on <= req_lock[win];
            lock_id <= win;
        end
    end
`else
    assign elig = req_valid;
`endif

    // Rotate requests so the channel after the pointer sits at bit 0
    always_comb begin
        base = {1'b0, ptr} + (SELW+1)'(1);
        rot  = N'({elig, elig} >> base);
    end

    // Winner: lowest index (fixed) or first after pointer (round-robin)
    always_comb begin
        pick   = (MODE == 0) ? pick_low(elig) : pick_low(rot);
        any    = pick[SELW];
        rr_sum = base + {1'b0, pick[SELW-1:0]};
        if (rr_sum >= (SELW+1)'(N)) rr_sum = rr_sum - (SELW+1)'(N);
        win    = (MODE == 0) ? pick[SELW-1:0] : rr_sum[SELW-1:0];
    end

    // Grant is one-hot on a free slot, forced low while in reset
    always_comb begin
        req_ready = '0;
        if (xfer && reset_n) req_ready = N'(1) << win;
    end

    // Round-robin pointer remembers the last granted channel
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= SELW'(N - 1);
        end else if (xfer) begin
            ptr <= win;
        end
    end

    // Output register loads on a free slot; payload held when idle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else if (slot_free) begin
            out_valid <= any;
            if (any) begin
                out_data <= chan[win];
                out_sel  <= win;
            end
        end
    end

endmodule

// File: tb/tb_muxn_arb.sv
// tb_muxn_arb: directed test of muxn_arb, round-robin and fixed-priority.
// Lock sequence runs when MUXN_ARB_LOCK_EN is defined.
module tb_muxn_arb;

    localparam int W = 32;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset_n = 1'b1;

    logic [N-1:0]   v1 = '0, rr1;
    logic [N*W-1:0] d1 = '0;
    logic [N-1:0]   lk1 = '0;
    logic           ov1, ordy1 = 1'b1;
    logic [W-1:0]   od1;
    logic [1:0]     os1;

    logic [N-1:0]   v0 = '0, rr0;
    logic [N*W-1:0] d0 = '0;
    logic [N-1:0]   lk0 = '0;
    logic           ov0, ordy0 = 1'b1;
    logic [W-1:0]   od0;
    logic [1:0]     os0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    muxn_arb #(.WIDTH(W), .N(N), .MODE(1)) u_rr (
        .clk(clk), .reset_n(reset_n),
        .req_valid(v1), .req_data(d1),
`ifdef MUXN_ARB_LOCK_EN
        .req_lock(lk1),
`endif
        .req_ready(rr1), .out_valid(ov1), .out_data(od1),
        .out_sel(os1), .out_ready(ordy1)
    );

    muxn_arb #(.WIDTH(W), .N(N), .MODE(0)) u_fp (
        .clk(clk), .reset_n(reset_n),
        .req_valid(v0), .req_data(d0),
`ifdef MUXN_ARB_LOCK_EN
        .req_lock(lk0),
`endif
        .req_ready(rr0), .out_valid(ov0), .out_data(od0),
        .out_sel(os0), .out_ready(ordy0)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat1(input string tag, input logic [1:0] sel,
                         input logic [W-1:0] data);
        chk({tag, "_v"}, 64'(ov1), 64'd1);
        chk({tag, "_sel"}, 64'(os1), 64'(sel));
        chk({tag, "_data"}, 64'(od1), 64'(data));
    endtask

    initial begin
        #2 reset_n = 1'b0;
        tick();
        tick();
        v1 = 4'hF;
        for (int i = 0; i < N; i++) d1[i*W +: W] = 32'hC0DE_0000 + i;
        #1;
        chk("rst_v", 64'(ov1), 64'd0);
        chk("rst_data", 64'(od1), 64'd0);
        chk("rst_sel", 64'(os1), 64'd0);
        chk("rst_rdy", 64'(rr1), 64'd0);
        reset_n = 1'b1;
        #1;
        chk("rr_first_rdy", 64'(rr1), 64'b0001);
        tick();
        beat1("rr0", 2'd0, 32'hC0DE_0000);
        for (int i = 1; i <= 5; i++) begin
            chk("rr_rdy", 64'(rr1), 64'(4'b0001 << (i % 4)));
            tick();
            beat1("rr_seq", 2'(i % 4), 32'hC0DE_0000 + 32'(i % 4));
        end

        // reset while a beat is pending
        reset_n = 1'b0;
        #1;
        chk("mid_rst_v", 64'(ov1), 64'd0);
        chk("mid_rst_data", 64'(od1), 64'd0);
        chk("mid_rst_sel", 64'(os1), 64'd0);
        chk("mid_rst_rdy", 64'(rr1), 64'd0);
        tick();
        reset_n = 1'b1;
        #1;
        chk("post_rst_rdy", 64'(rr1), 64'b0001);
        tick();
        beat1("post_rst", 2'd0, 32'hC0DE_0000);

        // single channel 2
        v1 = 4'b0100;
        d1[2*W +: W] = 32'hA5A5_A5A5;
        #1;
        chk("single_rdy", 64'(rr1), 64'b0100);
        tick();
        beat1("single", 2'd2, 32'hA5A5_A5A5);
        v1 = '0;
        #1;
        chk("idle_rdy", 64'(rr1), 64'd0);
        tick();
        chk("idle_v", 64'(ov1), 64'd0);
        chk("idle_hold_data", 64'(od1), 64'hA5A5_A5A5);
        chk("idle_hold_sel", 64'(os1), 64'd2);

        // backpressure
        v1 = 4'b0001;
        d1[0 +: W] = 32'h1234_5678;
        #1;
        chk("bp_pre_rdy", 64'(rr1), 64'b0001);
        tick();
        beat1("bp_pre", 2'd0, 32'h1234_5678);
        ordy1 = 1'b0;
        d1[0 +: W] = 32'h0BAD_F00D;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_rdy", 64'(rr1), 64'd0);
            tick();
            beat1("bp_hold", 2'd0, 32'h1234_5678);
        end
        ordy1 = 1'b1;
        #1;
        chk("bp_release_rdy", 64'(rr1), 64'b0001);
        tick();
        beat1("bp_release", 2'd0, 32'h0BAD_F00D);

`ifdef MUXN_ARB_LOCK_EN
        d1[0 +: W] = 32'h0000_0C00;
        v1 = 4'b0101; lk1 = 4'b0100; d1[2*W +: W] = 32'hB0;
        #1;
        chk("lk_a_rdy", 64'(rr1), 64'b0100);
        tick();
        beat1("lk_a", 2'd2, 32'hB0);
        d1[2*W +: W] = 32'hB1;
        #1;
        chk("lk_b_rdy", 64'(rr1), 64'b0100);
        tick();
        beat1("lk_b", 2'd2, 32'hB1);
        v1 = 4'b0001;
        #1;
        chk("lk_idle_rdy", 64'(rr1), 64'd0);
        tick();
        chk("lk_bubble_v", 64'(ov1), 64'd0);
        v1 = 4'b0101; d1[2*W +: W] = 32'hB2;
        #1;
        chk("lk_c_rdy", 64'(rr1), 64'b0100);
        tick();
        beat1("lk_c", 2'd2, 32'hB2);
        lk1 = 4'b0000; d1[2*W +: W] = 32'hB3;
        #1;
        chk("lk_d_rdy", 64'(rr1), 64'b0100);
        tick();
        beat1("lk_d", 2'd2, 32'hB3);
        v1 = 4'b0001;
        #1;
        chk("lk_free_rdy", 64'(rr1), 64'b0001);
        tick();
        beat1("lk_free", 2'd0, 32'h0000_0C00);
`endif
        v1 = '0;

        // fixed priority instance
        d0[1*W +: W] = 32'h1111_0001;
        d0[3*W +: W] = 32'h3333_0003;
        v0 = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("fp_rdy", 64'(rr0), 64'b0010);
            tick();
            chk("fp_v", 64'(ov0), 64'd1);
            chk("fp_sel", 64'(os0), 64'd1);
            chk("fp_data", 64'(od0), 64'h1111_0001);
        end
        v0 = 4'b1000;
        #1;
        chk("fp_drop_rdy", 64'(rr0), 64'b1000);
        tick();
        chk("fp_drop_sel", 64'(os0), 64'd3);
        chk("fp_drop_data", 64'(od0), 64'h3333_0003);
        v0 = '0;
        tick();
        chk("fp_idle_v", 64'(ov0), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
